// File: rtl/mips_pkg.sv
// Shared constants and the dump-reader state type for the 32x32 register file.
package mips_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } dump_state_t;

  // Index of the final register walked for a given register count.
  function automatic logic [REG_AW-1:0] last_index(input int nregs);
    return REG_AW'(nregs - 1);
  endfunction

endpackage

// File: rtl/regdump_checksum.sv
// XOR accumulator over handshaken dump words; clear has priority over enable.
module regdump_checksum
  import mips_pkg::*;
#(
  parameter int DW = REG_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] sum
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks RegFile read port A over every register and streams each value out on valid/ready.
// Optional XOR checksum of the dumped words when REGDUMP_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | ra parked at 0, waiting for start
// READ  | capture busa/ra into the output registers
// SEND  | word presented, waiting for out_ready
// FIN   | pulse done, drop busy, return to IDLE
module regfile_dump_reader
  import mips_pkg::*;
#(
  parameter int NREGS = NUM_REGS,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] busa,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  dump_state_t   state, state_nx;
  logic          busy_nx, done_nx, valid_nx;
  logic [AW-1:0] ra_nx, idx_nx;
  logic [DW-1:0] data_nx;
  logic          accept, hshk;

  // A start seen alongside the done pulse belongs to the finished dump.
  assign accept = (state == IDLE) && start && !done;
  assign hshk   = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ra        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      state     <= state_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      ra        <= ra_nx;
      out_valid <= valid_nx;
      out_data  <= data_nx;
      out_idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy_nx  = busy;
    done_nx  = 1'b0;
    ra_nx    = ra;
    valid_nx = out_valid;
    data_nx  = out_data;
    idx_nx   = out_idx;
    case (state)
      IDLE: begin
        ra_nx = '0;
        if (accept) begin
          busy_nx  = 1'b1;
          state_nx = READ;
        end
      end
      READ: begin
        data_nx  = busa;
        idx_nx   = ra;
        valid_nx = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        if (hshk) begin
          valid_nx = 1'b0;
          if (ra == LAST) begin
            state_nx = FIN;
          end else begin
            ra_nx    = ra + 1'b1;
            state_nx = READ;
          end
        end
      end
      FIN: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        ra_nx    = '0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef REGDUMP_CHECKSUM_EN
  regdump_checksum #(
    .DW(DW)
  ) u_checksum (
    .clk  (clk),
    .reset(reset),
    .clr  (accept),
    .en   (hshk),
    .din  (out_data),
    .sum  (checksum)
  );
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized scoreboard bench for regfile_dump_reader with a behavioural RegFile alongside.
module tb_regfile_dump_reader;
  import mips_pkg::*;

  localparam int NREGS = NUM_REGS;
  localparam int AW    = REG_AW;
  localparam int DW    = REG_DW;

  localparam int HK_NONE    = 0;
  localparam int HK_STALL   = 1;
  localparam int HK_RESTART = 2;
  localparam int HK_RESET   = 3;
  localparam int HK_WRITE   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] ra, out_idx;
  logic [DW-1:0] busa, out_data;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] mem    [NREGS];
  logic [DW-1:0] shadow [NREGS];

  logic [AW-1:0] qi [$];
  logic [DW-1:0] qd [$];
  logic [DW-1:0] cs_model = '0;
  int            errors = 0;
  int            checks = 0;
  int            done_cnt = 0;

  regfile_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ra       (ra),
    .busa     (busa),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx)
`ifdef REGDUMP_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RegFile: register 0 reads 0, a same-cycle write is visible on the read port.
  initial for (int i = 0; i < NREGS; i++) begin
    mem[i] = '0;
    shadow[i] = '0;
  end
  always @(posedge clk) if (we && wa != '0) mem[wa] <= wd;
  assign busa = (ra == '0) ? '0 : ((we && wa == ra) ? wd : mem[ra]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected word on every handshake the DUT presents.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (qi.size() == 0) begin
        check("unexpected_word", {32'b0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        automatic logic [AW-1:0] ei = qi.pop_front();
        automatic logic [DW-1:0] ed = qd.pop_front();
        check("out_idx", {59'b0, out_idx}, {59'b0, ei});
        check("out_data", {32'b0, out_data}, {32'b0, ed});
        cs_model = cs_model ^ ed;
      end
    end
    if (reset && done) done_cnt++;
  end

  // Writes reach every register not yet captured; a word already presented keeps its value.
  task automatic do_write(input int j, input logic [DW-1:0] v);
    we = 1'b1;
    wa = AW'(j);
    wd = v;
    if (j != 0) begin
      shadow[j] = v;
      for (int n = (out_valid ? 1 : 0); n < qi.size(); n++)
        if (qi[n] == AW'(j)) qd[n] = v;
    end
  endtask

  task automatic preload(input int mode);
    for (int i = 0; i < NREGS; i++) begin
      case (mode)
        0:       do_write(i, DW'(i) * 32'h0101_0101);
        1:       do_write(i, DW'(i));
        2:       do_write(i, (i == NREGS - 1) ? 32'hFFFF_FFFF : 32'h0);
        default: do_write(i, $urandom());
      endcase
      @(posedge clk);
      #1 we = 1'b0;
    end
  endtask

  task automatic run_dump(input bit rnd_ready, input int hook);
    int k;
    int stage;
    int dc0;
    bit aborted;
    k = 0;
    stage = 0;
    aborted = 0;
    dc0 = done_cnt;
    for (int i = 0; i < NREGS; i++) begin
      qi.push_back(AW'(i));
      qd.push_back(shadow[i]);
    end
    cs_model = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", {63'b0, busy}, 64'd1);
    while (!done && k < 4000 && !aborted) begin
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && stage == 0) begin
        if (hook == HK_STALL && out_idx == AW'(7)) begin
          stage = 1;
          out_ready = 1'b0;
          repeat (5) begin
            @(posedge clk);
            #1 k++;
            check("stall_valid", {63'b0, out_valid}, 64'd1);
            check("stall_idx", {59'b0, out_idx}, 64'd7);
            check("stall_data", {32'b0, out_data}, {32'b0, shadow[7]});
            check("stall_ra", {59'b0, ra}, 64'd7);
          end
          out_ready = 1'b1;
        end else if (hook == HK_RESTART && out_idx == AW'(10)) begin
          stage = 1;
          start = 1'b1;
        end else if (hook == HK_WRITE && out_idx == AW'(5)) begin
          stage = 1;
          do_write(20, 32'hDEAD_BEEF);
        end else if (hook == HK_RESET && out_idx == AW'(15)) begin
          stage = 1;
          #2 reset = 1'b0;
          #1;
          check("rst_busy", {63'b0, busy}, 64'd0);
          check("rst_done", {63'b0, done}, 64'd0);
          check("rst_valid", {63'b0, out_valid}, 64'd0);
          check("rst_ra", {59'b0, ra}, 64'd0);
          check("rst_data", {32'b0, out_data}, 64'd0);
          check("rst_idx", {59'b0, out_idx}, 64'd0);
          qi.delete();
          qd.delete();
          repeat (2) @(posedge clk);
          #1 reset = 1'b1;
          aborted = 1;
        end
      end else if (hook == HK_WRITE && stage == 1) begin
        stage = 2;
        do_write(3, ~shadow[3]);
      end
      if (!aborted) begin
        @(posedge clk);
        #1 k++;
        start = 1'b0;
        we = 1'b0;
      end
    end
    if (aborted) return;
    check("done_seen", {63'b0, done}, 64'd1);
    if (!rnd_ready && (hook == HK_NONE || hook == HK_RESTART || hook == HK_WRITE))
      check("dump_latency", 64'(k), 64'(2 * NREGS + 1));
    check("words_left", 64'(qi.size()), 64'd0);
`ifdef REGDUMP_CHECKSUM_EN
    check("checksum_at_done", {32'b0, checksum}, {32'b0, cs_model});
`endif
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_with_done_ignored", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'b0, done}, 64'd0);
    check("done_count", 64'(done_cnt - dc0), 64'd1);
`ifdef REGDUMP_CHECKSUM_EN
    check("checksum_stable", {32'b0, checksum}, {32'b0, cs_model});
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 reset = 1'b0;
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_valid", {63'b0, out_valid}, 64'd0);
    check("reset_ra", {59'b0, ra}, 64'd0);
    check("reset_data", {32'b0, out_data}, 64'd0);
    check("reset_idx", {59'b0, out_idx}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    preload(0);
    run_dump(1'b0, HK_NONE);
    run_dump(1'b0, HK_STALL);
    run_dump(1'b0, HK_RESTART);

    run_dump(1'b0, HK_RESET);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_after_reset_busy", {63'b0, busy}, 64'd0);
      check("idle_after_reset_valid", {63'b0, out_valid}, 64'd0);
    end
    run_dump(1'b0, HK_NONE);

    run_dump(1'b0, HK_WRITE);

    for (int r = 0; r < 3; r++) begin
      preload(3);
      run_dump(1'b1, HK_NONE);
    end

`ifdef REGDUMP_CHECKSUM_EN
    preload(1);
    run_dump(1'b0, HK_NONE);
    check("checksum_index_values", {32'b0, checksum}, 64'h0);
    preload(2);
    run_dump(1'b1, HK_NONE);
    check("checksum_top_reg_ones", {32'b0, checksum}, 64'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
